// File: rtl/length_accumulator.sv
// Packing-offset controller for the compressor output stage.
// Tracks the chunk write offset in a line buffer and emits line-writer pulses.
module length_accumulator #(
    parameter int CACHE_LINE = 128,
    parameter int WORD_SIZE  = 64
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [6:0] i_total_length,
    output logic       o_store_flag,
    output logic [7:0] o_shift_amount,
    output logic       o_fill_flag,
    output logic       o_output_flag,
    output logic       o_fill_ctrl,
    output logic       o_stop_flag,
    output logic       o_done_flag,
    output logic       o_finish_final,
    output logic       o_push_flag
);

    localparam logic [7:0] LP_LINE = 8'(CACHE_LINE);
    localparam logic [7:0] LP_WORD = 8'(WORD_SIZE);

    logic [7:0] r_cnt;
    logic       r_fill_ctrl;
    logic       r_push;
    logic       r_push_n2;
    logic       r_final;

    logic [7:0] w_sum;
    logic [7:0] w_cnt_next;
    logic       w_store;
    logic       w_output;
    logic       w_stop;
    logic       w_fill;

    // Both operands stay below CACHE_LINE, so the 8-bit sum never wraps.
    assign w_sum      = r_cnt + {1'b0, i_total_length};
    assign w_store    = (i_total_length != 7'd0);
    assign w_output   = (r_cnt < LP_WORD) && (w_sum >= LP_WORD);
    assign w_stop     = (w_sum >= LP_LINE);
    assign w_fill     = (w_sum > LP_LINE);
    assign w_cnt_next = w_stop ? (w_sum - LP_LINE) : w_sum;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt       <= 8'd0;
            r_fill_ctrl <= 1'b0;
            r_push      <= 1'b0;
            r_push_n2   <= 1'b0;
            r_final     <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_fill_ctrl <= w_fill;
            r_push      <= w_stop;
            r_push_n2   <= r_push;
            r_final     <= r_push_n2;
        end
    end

    // Length input is live during reset, so gate everything explicitly.
    assign o_store_flag   = ~i_reset & w_store;
    assign o_shift_amount = i_reset ? 8'd0 : r_cnt;
    assign o_output_flag  = ~i_reset & w_output;
    assign o_stop_flag    = ~i_reset & w_stop;
    assign o_fill_flag    = ~i_reset & w_fill;
    assign o_fill_ctrl    = ~i_reset & r_fill_ctrl;
    assign o_push_flag    = ~i_reset & r_push;
    assign o_done_flag    = ~i_reset & r_push_n2;
    assign o_finish_final = ~i_reset & r_final;

endmodule

// File: tb/tb_length_accumulator.sv
// Directed + random bench for length_accumulator.
// Expected outputs are queued at drive time and popped at the falling edge.
module tb_length_accumulator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] len = 7'd0;
    logic       store, fill, outp, fillc, stop, done, fin, push;
    logic [7:0] shift;

    length_accumulator dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_total_length (len),
        .o_store_flag   (store),
        .o_shift_amount (shift),
        .o_fill_flag    (fill),
        .o_output_flag  (outp),
        .o_fill_ctrl    (fillc),
        .o_stop_flag    (stop),
        .o_done_flag    (done),
        .o_finish_final (fin),
        .o_push_flag    (push)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       store;
        logic [7:0] shift;
        logic       fill, outp, fillc, stop, done, fin, push;
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // Reference model: bit position in the line plus stop history.
    int m_pos = 0;
    bit m_h1 = 0, m_h2 = 0, m_h3 = 0, m_pfill = 0;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int l, input bit r, input int want_shift);
        exp_t e;
        int   s;
        @(posedge clk);
        #1;
        rst = r;
        len = 7'(l);
        e = '{store:0, shift:0, fill:0, outp:0, fillc:0,
              stop:0, done:0, fin:0, push:0};
        if (r) begin
            m_pos = 0;
            {m_h1, m_h2, m_h3, m_pfill} = 4'b0;
        end else begin
            s       = m_pos + l;
            e.store = (l != 0);
            e.shift = 8'(m_pos);
            e.outp  = (m_pos < 64) && (s >= 64);
            e.stop  = (s >= 128);
            e.fill  = (s > 128);
            e.fillc = m_pfill;
            e.push  = m_h1;
            e.done  = m_h2;
            e.fin   = m_h3;
            m_h3    = m_h2;
            m_h2    = m_h1;
            m_h1    = e.stop;
            m_pfill = e.fill;
            m_pos   = e.stop ? s - 128 : s;
        end
        q.push_back(e);
        @(negedge clk);
        e = q.pop_front();
        chk("store", 8'(store), 8'(e.store));
        chk("shift", shift, e.shift);
        chk("fill", 8'(fill), 8'(e.fill));
        chk("output", 8'(outp), 8'(e.outp));
        chk("fill_ctrl", 8'(fillc), 8'(e.fillc));
        chk("stop", 8'(stop), 8'(e.stop));
        chk("push", 8'(push), 8'(e.push));
        chk("done", 8'(done), 8'(e.done));
        chk("final", 8'(fin), 8'(e.fin));
        if (want_shift >= 0)
            chk("spec_shift", shift, 8'(want_shift));
    endtask

    initial begin
        #2 rst = 1'b1;
        // reset held with a live length
        step(40, 1, 0);
        step(40, 1, 0);
        // exact line
        step(40, 0, 0);
        step(12, 0, 40);
        step(12, 0, 52);
        chk("exact_out", 8'(outp), 8'd1);
        step(24, 0, 64);
        step(32, 0, 88);
        step(8, 0, 120);
        chk("exact_stop", 8'(stop), 8'd1);
        chk("exact_nofill", 8'(fill), 8'd0);
        // second line; push/done/final of first stop ride along
        step(48, 0, 0);
        chk("line1_push", 8'(push), 8'd1);
        step(8, 0, 48);
        chk("line1_done", 8'(done), 8'd1);
        step(68, 0, 56);
        chk("line1_final", 8'(fin), 8'd1);
        chk("line2_out", 8'(outp), 8'd1);
        step(4, 0, 124);
        chk("line2_stop", 8'(stop), 8'd1);
        // spill
        step(60, 0, 0);
        step(60, 0, 60);
        step(20, 0, 120);
        chk("spill_fill", 8'(fill), 8'd1);
        step(48, 0, 12);
        chk("spill_fctl", 8'(fillc), 8'd1);
        // dual event at cnt=60
        step(100, 0, 60);
        chk("dual_out", 8'(outp), 8'd1);
        chk("dual_stop", 8'(stop), 8'd1);
        // idle holds
        step(0, 0, 32);
        step(0, 0, 32);
        // back-to-back stops
        step(95, 0, 32);
        step(127, 0, 127);
        step(127, 0, 126);
        step(0, 0, 125);
        step(0, 0, 125);
        step(0, 0, 125);
        // reset right after a stop kills the pulse train
        step(3, 0, 125);
        chk("pre_rst_stop", 8'(stop), 8'd1);
        step(0, 1, 0);
        step(0, 0, 0);
        chk("rst_push", 8'(push), 8'd0);
        step(0, 0, 0);
        chk("rst_done", 8'(done), 8'd0);
        step(0, 0, 0);
        chk("rst_final", 8'(fin), 8'd0);
        // random traffic with occasional reset
        for (int i = 0; i < 300; i++) begin
            step(int'($urandom_range(0, 127)),
                 ($urandom_range(0, 31) == 0), -1);
        end
        step(0, 0, -1);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
